vga_timing_gen: RTL and testbench

- Pixel/line timing generator for the VGA path; the source end of the position bus that the 11-bit match comparators consume.
- Runs an 11-bit horizontal counter and an 11-bit vertical counter, and decodes hsync, vsync and active-video from a bank of loadable boundary registers.
- Boundary values are written into shadow registers over a simple register port. They are applied only at a frame boundary, so the raster never tears.

---
 rtl/vga_timing_gen_if.sv | 22 ++
 rtl/vga_timing_gen.sv | 143 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Register port of the VGA timing generator: shadow writes, commit request
// and the pending/error status returned by the generator.
interface vga_timing_gen_if #(
    parameter int CW = 11
);
    logic          cfg_wr;
    logic [2:0]    cfg_addr;
    logic [CW-1:0] cfg_data;
    logic          cfg_commit;
    logic          cfg_pending;
    logic          cfg_err;

    modport master (
        output cfg_wr, cfg_addr, cfg_data, cfg_commit,
        input  cfg_pending, cfg_err
    );

    modport slave (
        input  cfg_wr, cfg_addr, cfg_data, cfg_commit,
        output cfg_pending, cfg_err
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA pixel/line timing generator. Boundary values are staged in shadow
// registers and moved to the working set only at a frame wrap.
module vga_timing_gen #(
    parameter int CW       = 11,
    parameter bit SYNC_POL = 1'b0,
    parameter int H_ACT_D  = 640,
    parameter int H_SS_D   = 656,
    parameter int H_SE_D   = 752,
    parameter int H_TOT_D  = 800,
    parameter int V_ACT_D  = 480,
    parameter int V_SS_D   = 490,
    parameter int V_SE_D   = 492,
    parameter int V_TOT_D  = 525
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pix_en,
    vga_timing_gen_if.slave cfg,
    output logic [CW-1:0]   h_count,
    output logic [CW-1:0]   v_count,
    output logic            hsync,
    output logic            vsync,
    output logic            active,
    output logic            line_start,
    output logic            frame_start
);
    localparam logic [2:0] A_H_ACT = 3'd0;
    localparam logic [2:0] A_H_SS  = 3'd1;
    localparam logic [2:0] A_H_SE  = 3'd2;
    localparam logic [2:0] A_H_TOT = 3'd3;
    localparam logic [2:0] A_V_ACT = 3'd4;
    localparam logic [2:0] A_V_SS  = 3'd5;
    localparam logic [2:0] A_V_SE  = 3'd6;
    localparam logic [2:0] A_V_TOT = 3'd7;

    localparam logic [CW-1:0] ZERO_W = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_W  = CW'(1);
    localparam logic [CW-1:0] TWO_W  = CW'(2);

    localparam logic [7:0][CW-1:0] REG_DEFAULTS = {
        CW'(V_TOT_D), CW'(V_SE_D), CW'(V_SS_D), CW'(V_ACT_D),
        CW'(H_TOT_D), CW'(H_SE_D), CW'(H_SS_D), CW'(H_ACT_D)
    };

    logic [CW-1:0]         h_q, h_d, v_q, v_d;
    logic [7:0][CW-1:0]    shd_q, shd_d, wrk_q, wrk_d;
    logic                  pend_q, pend_d, err_q, err_d;
    logic                  h_last_s, v_last_s, frame_wrap_s;

    function automatic logic cfg_valid(input logic [7:0][CW-1:0] r);
        logic ok;
        ok = (r[A_H_TOT] >= TWO_W) && (r[A_V_TOT] >= TWO_W)
          && (r[A_H_ACT] <= r[A_H_TOT])
          && (r[A_H_SS] <= r[A_H_SE]) && (r[A_H_SE] <= r[A_H_TOT])
          && (r[A_V_ACT] <= r[A_V_TOT])
          && (r[A_V_SS] <= r[A_V_SE]) && (r[A_V_SE] <= r[A_V_TOT]);
        return ok;
    endfunction

    assign h_last_s     = (h_q == (wrk_q[A_H_TOT] - ONE_W));
    assign v_last_s     = (v_q == (wrk_q[A_V_TOT] - ONE_W));
    assign frame_wrap_s = pix_en && h_last_s && v_last_s;

    // Next-state: shadow writes, raster counters, commit validation and apply
    always_comb begin
        shd_d  = shd_q;
        wrk_d  = wrk_q;
        h_d    = h_q;
        v_d    = v_q;
        pend_d = pend_q;
        err_d  = 1'b0;

        if (cfg.cfg_wr) begin
            shd_d[cfg.cfg_addr] = cfg.cfg_data;
        end else begin
            shd_d = shd_q;
        end

        if (pix_en) begin
            if (h_last_s) begin
                h_d = ZERO_W;
                if (v_last_s) begin
                    v_d = ZERO_W;
                end else begin
                    v_d = v_q + ONE_W;
                end
            end else begin
                h_d = h_q + ONE_W;
            end
        end else begin
            h_d = h_q;
            v_d = v_q;
        end

        // Apply uses the pre-edge shadow; a commit in this cycle re-arms for the next wrap
        if (frame_wrap_s && pend_q) begin
            wrk_d  = shd_q;
            pend_d = 1'b0;
        end else begin
            wrk_d = wrk_q;
        end

        if (cfg.cfg_commit) begin
            if (cfg_valid(shd_d)) begin
                pend_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            err_d = 1'b0;
        end
    end

    // State registers with synchronous reset to the default timing
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q    <= ZERO_W;
            v_q    <= ZERO_W;
            shd_q  <= REG_DEFAULTS;
            wrk_q  <= REG_DEFAULTS;
            pend_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            shd_q  <= shd_d;
            wrk_q  <= wrk_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign h_count     = h_q;
    assign v_count     = v_q;
    assign active      = (h_q < wrk_q[A_H_ACT]) && (v_q < wrk_q[A_V_ACT]);
    assign hsync       = ((h_q >= wrk_q[A_H_SS]) && (h_q < wrk_q[A_H_SE])) ? SYNC_POL : ~SYNC_POL;
    assign vsync       = ((v_q >= wrk_q[A_V_SS]) && (v_q < wrk_q[A_V_SE])) ? SYNC_POL : ~SYNC_POL;
    assign line_start  = pix_en && (h_q == ZERO_W);
    assign frame_start = line_start && (v_q == ZERO_W);

    assign cfg.cfg_pending = pend_q;
    assign cfg.cfg_err     = err_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: stimulus queues expected values,
// a negedge monitor compares them and measures frame lengths.
module tb_vga_timing_gen;
    localparam int CW = 11;

    localparam int S_H = 0, S_V = 1, S_HS = 2, S_VS = 3, S_ACT = 4;
    localparam int S_LS = 5, S_FS = 6, S_PEND = 7, S_ERR = 8;

    typedef struct {
        string name;
        int    sel;
        int    val;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          pix_en;
    logic [CW-1:0] h_count, v_count;
    logic          hsync, vsync, active, line_start, frame_start;

    vga_timing_gen_if #(.CW(CW)) cfg_if ();

    // Vertical defaults shortened so that one default frame is 8000 clocks
    vga_timing_gen #(
        .CW(CW), .SYNC_POL(1'b0),
        .H_ACT_D(640), .H_SS_D(656), .H_SE_D(752), .H_TOT_D(800),
        .V_ACT_D(6), .V_SS_D(7), .V_SE_D(9), .V_TOT_D(10)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .cfg(cfg_if),
        .h_count(h_count), .v_count(v_count), .hsync(hsync), .vsync(vsync),
        .active(active), .line_start(line_start), .frame_start(frame_start)
    );

    exp_t exp_q[$];
    int   frm_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   ncyc   = 0;
    int   fs_prev = 0;
    bit   fs_prev_valid = 1'b0;
    exp_t e;
    int   flen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, got, want);
    endtask

    function automatic int sig(input int sel);
        case (sel)
            S_H:    return int'(h_count);
            S_V:    return int'(v_count);
            S_HS:   return int'(hsync);
            S_VS:   return int'(vsync);
            S_ACT:  return int'(active);
            S_LS:   return int'(line_start);
            S_FS:   return int'(frame_start);
            S_PEND: return int'(cfg_if.cfg_pending);
            S_ERR:  return int'(cfg_if.cfg_err);
            default: return -1;
        endcase
    endfunction

    // Monitor: drain expectations and time frame_start-to-frame_start intervals
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.name, sig(e.sel), e.val);
        end
        if (rst) begin
            fs_prev_valid = 1'b0;
        end else if (frame_start) begin
            if (fs_prev_valid && frm_q.size() > 0) begin
                flen = frm_q.pop_front();
                chk("frame_len", ncyc - fs_prev, flen);
            end
            fs_prev = ncyc;
            fs_prev_valid = 1'b1;
        end
        ncyc++;
    end

    task automatic ex(input string nm, input int sel, input int val);
        exp_t t;
        t.name = nm;
        t.sel  = sel;
        t.val  = val;
        exp_q.push_back(t);
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int a, input int d);
        cfg_if.cfg_wr   = 1'b1;
        cfg_if.cfg_addr = 3'(a);
        cfg_if.cfg_data = CW'(d);
        adv(1);
        cfg_if.cfg_wr   = 1'b0;
    endtask

    task automatic commit();
        cfg_if.cfg_commit = 1'b1;
        adv(1);
        cfg_if.cfg_commit = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pix_en = 1'b0;
        cfg_if.cfg_wr = 1'b0;
        cfg_if.cfg_addr = 3'd0;
        cfg_if.cfg_data = {CW{1'b0}};
        cfg_if.cfg_commit = 1'b0;
        // Frames: default+gated line, three 80-clock frames of the small timing
        frm_q.push_back(8800);
        frm_q.push_back(80);
        frm_q.push_back(80);
        frm_q.push_back(80);
        adv(2);
        rst = 1'b0;

        // Reset state
        ex("rst_h", S_H, 0); ex("rst_v", S_V, 0); ex("rst_active", S_ACT, 1);
        ex("rst_hsync", S_HS, 1); ex("rst_vsync", S_VS, 1); ex("rst_pend", S_PEND, 0);
        ex("rst_err", S_ERR, 0); ex("rst_ls_noen", S_LS, 0); ex("rst_fs_noen", S_FS, 0);
        adv(1);
        ex("hold_noen_h", S_H, 0);
        pix_en = 1'b1;
        ex("fs_first", S_FS, 1); ex("ls_first", S_LS, 1);

        // Default horizontal boundaries on line 0
        adv(639); ex("act_639", S_ACT, 1);
        adv(1);   ex("act_640", S_ACT, 0);
        adv(15);  ex("hs_655", S_HS, 1);
        adv(1);   ex("hs_656", S_HS, 0);
        adv(95);  ex("hs_751", S_HS, 0); ex("h_751", S_H, 751);
        adv(1);   ex("hs_752", S_HS, 1);
        adv(47);  ex("h_799", S_H, 799); ex("v_line0", S_V, 0);
        adv(1);   ex("h_wrap", S_H, 0); ex("v_line1", S_V, 1);
        ex("ls_line1", S_LS, 1); ex("fs_line1", S_FS, 0);

        // Enable gating: alternate pix_en for one line
        for (int i = 0; i < 1600; i++) begin
            pix_en = (i % 2 == 0);
            if (i == 1) begin ex("gate_h1", S_H, 1); ex("gate_ls", S_LS, 0); end
            if (i == 2) ex("gate_hold", S_H, 1);
            if (i == 3) ex("gate_h2", S_H, 2);
            adv(1);
        end
        pix_en = 1'b1;
        ex("gate_line_h", S_H, 0); ex("gate_line_v", S_V, 2); ex("gate_ls2", S_LS, 1);

        // Reconfigure mid-frame at line 3
        adv(800);
        cfg_write(3, 20); cfg_write(0, 10); cfg_write(1, 12); cfg_write(2, 14);
        cfg_write(7, 4);  cfg_write(4, 2);  cfg_write(5, 2);  cfg_write(6, 3);
        commit();
        ex("cmt_pend", S_PEND, 1); ex("cmt_err", S_ERR, 0);
        ex("cmt_h", S_H, 9); ex("cmt_v", S_V, 3);
        adv(3191); ex("old_v7", S_V, 7); ex("old_vs7", S_VS, 0);
        adv(2399); ex("old_v9", S_V, 9); ex("old_h799", S_H, 799);
        ex("old_vs9", S_VS, 1); ex("old_pend", S_PEND, 1);
        adv(1); ex("apply_pend", S_PEND, 0); ex("apply_fs", S_FS, 1); ex("apply_act", S_ACT, 1);

        // New small timing: 20x4
        adv(19); ex("new_h19", S_H, 19); ex("new_act19", S_ACT, 0);
        adv(1);  ex("new_hwrap", S_H, 0); ex("new_v1", S_V, 1);
        adv(12); ex("new_hs12", S_HS, 0);
        adv(2);  ex("new_hs14", S_HS, 1);
        adv(6);  ex("new_v2", S_V, 2); ex("new_vs2", S_VS, 0); ex("new_act_v2", S_ACT, 0);
        adv(20); ex("new_vs3", S_VS, 1);
        adv(20); ex("new_fwrap", S_FS, 1);

        // Commit exactly on the frame-wrap cycle
        cfg_write(3, 30);
        adv(78); ex("col_pre_h", S_H, 19); ex("col_pre_v", S_V, 3);
        commit();
        ex("col_h0", S_H, 0); ex("col_pend", S_PEND, 1); ex("col_fs", S_FS, 1);
        adv(79); ex("col_old_h19", S_H, 19); ex("col_old_pend", S_PEND, 1);
        adv(1);  ex("col_apply_h", S_H, 0); ex("col_apply_v", S_V, 0); ex("col_apply_pend", S_PEND, 0);
        adv(29); ex("col_new_h29", S_H, 29);
        adv(1);  ex("col_new_wrap", S_H, 0); ex("col_new_v1", S_V, 1);

        // Invalid commit with a same-cycle write
        cfg_write(3, 800);
        cfg_if.cfg_wr = 1'b1; cfg_if.cfg_addr = 3'd2; cfg_if.cfg_data = CW'(900);
        cfg_if.cfg_commit = 1'b1;
        adv(1);
        cfg_if.cfg_wr = 1'b0; cfg_if.cfg_commit = 1'b0;
        ex("bad_err", S_ERR, 1); ex("bad_pend", S_PEND, 0); ex("bad_h", S_H, 2);
        adv(1);  ex("bad_err_pulse", S_ERR, 0);
        adv(26); ex("bad_keep_h29", S_H, 29);
        adv(1);  ex("bad_keep_wrap", S_H, 0); ex("bad_keep_v2", S_V, 2);

        // Valid commit pending, then reset mid-frame
        cfg_write(2, 14);
        commit(); ex("pre_rst_pend", S_PEND, 1); ex("pre_rst_err", S_ERR, 0);
        adv(28);  ex("pre_rst_v3", S_V, 3); ex("pre_rst_pend2", S_PEND, 1);
        rst = 1'b1;
        adv(1);
        rst = 1'b0;
        ex("mrst_h", S_H, 0); ex("mrst_v", S_V, 0); ex("mrst_pend", S_PEND, 0);
        ex("mrst_err", S_ERR, 0); ex("mrst_fs", S_FS, 1);
        adv(656); ex("mrst_h656", S_H, 656); ex("mrst_hs656", S_HS, 0); ex("mrst_act656", S_ACT, 0);
        adv(143); ex("mrst_h799", S_H, 799); ex("mrst_v0", S_V, 0);
        adv(1);   ex("mrst_wrap_h", S_H, 0); ex("mrst_wrap_v", S_V, 1);

        @(negedge clk);
        #1;
        chk("frames_seen", frm_q.size(), 0);
        chk("exp_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
